reg_file_8x16: RTL and testbench
================================

// Module: reg_file_8x16
// PURPOSE
//   Register file for the 16-bit single-cycle RISC core: 8 x 16-bit general registers.
//   Two combinational read ports feed the ALU operand path; one synchronous write port is
//   driven by the write-back stage.
//   - R0 is hard-wired to zero.
//   - Optional same-cycle write-to-read bypass.
//   - Per-register "written since reset" mask for debug and verification.
// PARAMETERS
//   DATA_W   16  register width in bits
//   NREG     8   number of registers (power of two)
//   ADDR_W   3   register address width, log2(NREG)
//   BYPASS   1   1: read port returns wd when writing the same address this cycle; 0: old value
// PORTS
//   clk      in   1        single clock; all state updates on posedge
//   rst      in   1        asynchronous, active-high reset
//   we       in   1        write enable from write-back stage
//   wa       in   ADDR_W   write address
//   wd       in   DATA_W   write data
//   ra1      in   ADDR_W   read address, port 1 (rs)
//   ra2      in   ADDR_W   read address, port 2 (rt)
//   rd1      out  DATA_W   read data, port 1 (combinational)
//   rd2      out  DATA_W   read data, port 2 (combinational)
//   rd1_uninit out 1       ra1 names a register not written since reset (never for R0)
//   rd2_uninit out 1       same for ra2
//   wmask    out  NREG     bit i = 1 when Ri has been written since reset; bit 0 is always 1
// BEHAVIOUR
//   Reset (rst=1, async, takes effect immediately, independent of clk):
//     - R1..R7 = 16'h0000.
//     - wmask = 8'b0000_0001.
//     - rd1/rd2 = 0 for any address, because the bypass is gated by !rst.
//   Write: on posedge clk with rst=0, we=1 and wa!=0: R[wa] <= wd and wmask[wa] <= 1.
//     - Otherwise every register holds its value.
//     - we=1 with wa=0 is a legal no-op; R0 and wmask[0] are unchanged.
//   Read: zero-latency combinational, rdN = (raN==0) ? 0 : R[raN].
//     - With BYPASS=1: if we && !rst && wa==raN && wa!=0, then rdN = wd.
//     - rdN_uninit follows the same bypass rule: the bypassed value counts as written.
//   Both read ports may address the same register, or the write address, in the same
//   cycle; each resolves independently with no priority between them.
//   Reset mid-operation: a write whose edge coincides with rst=1 is dropped. The first
//   write that takes effect is at the first posedge with rst=0.
//   Widths: no arithmetic. wd is stored unmodified. Addresses >= NREG cannot occur
//   (NREG = 2**ADDR_W).
//   No X propagation: every output is driven from reset onward.
// STRUCTURE
//   Shared package (rf_pkg):
//     - DATA_W, ADDR_W, NREG constants.
//     - Register-index localparams (R0_ZERO=0 ... R7=7) shared with decode and write-back.
//   Sub-module reg_word:
//     - DATA_W-bit register: clk, rst (async, active-high), we, d, q; holds when we=0.
//     - Instantiated for R1..R7 only.
//   Top level contains:
//     - wa/we one-hot write decoder;
//     - wmask flops;
//     - two read muxes with bypass and zero-force.
// TESTING
//   1 Reset: assert rst mid-cycle after loading R3=16'hBEEF -> R3 reads 0 immediately,
//     wmask=8'h01, rd1_uninit=1 for ra1=3.
//   2 Write/read: write R5=16'h1234; next cycle ra1=5, ra2=5 -> rd1=rd2=16'h1234,
//     wmask=8'h21.
//   3 R0 guard: we=1, wa=0, wd=16'hFFFF -> after the edge rd1(ra1=0)=0, wmask[0]=1,
//     other bits unchanged.
//   4 Bypass: R2=16'h0001, then same cycle we=1, wa=2, wd=16'hA5A5, ra1=2 ->
//     rd1=16'hA5A5 before the edge (BYPASS=1); rd1=16'h0001 when BYPASS=0.
//   5 Reset vs write: rst=1 spanning a posedge with we=1, wa=7, wd=16'h7777 ->
//     R7 stays 0 and wmask[7]=0 after rst deasserts.
//   6 Sweep: write Ri=16'h1111*i for i=1..7, then read all pairs (ra1, ra2) ->
//     matches the model, wmask=8'hFF, no uninit flags.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file constants and register-index names used by decode, write-back and the register file.
// Pure declarations; no logic, no latency, no flow control.
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [NREG-1:0]   regmask_t;

    localparam addr_t R0_ZERO = addr_t'(0);
    localparam addr_t R1      = addr_t'(1);
    localparam addr_t R2      = addr_t'(2);
    localparam addr_t R3      = addr_t'(3);
    localparam addr_t R4      = addr_t'(4);
    localparam addr_t R5      = addr_t'(5);
    localparam addr_t R6      = addr_t'(6);
    localparam addr_t R7      = addr_t'(7);

    // One-hot select for a write; R0 never gets a select bit.
    function automatic regmask_t wr_decode(input logic en, input addr_t a);
        regmask_t sel;
        sel = '0;
        if (en && (a != R0_ZERO)) begin
            sel[a] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_8x16_reg_word.sv
// One general-purpose register: loads d on a clock edge when we=1, otherwise holds.
// Latency one clock from d to q; async active-high reset clears to zero.
module reg_word
    import rf_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/reg_file_8x16.sv
// 8 x 16 register file: two combinational read ports, one synchronous write port, R0 reads zero.
// Reads are zero-latency with optional write bypass; writes land on the next clock edge; no backpressure.
module reg_file_8x16
    import rf_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int NREG_P   = NREG,
    parameter int ADDR_W_P = ADDR_W,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W_P-1:0] wa,
    input  logic [DATA_W_P-1:0] wd,
    input  logic [ADDR_W_P-1:0] ra1,
    input  logic [ADDR_W_P-1:0] ra2,
    output logic [DATA_W_P-1:0] rd1,
    output logic [DATA_W_P-1:0] rd2,
    output logic                rd1_uninit,
    output logic                rd2_uninit,
    output logic [NREG_P-1:0]   wmask
);

    logic [DATA_W_P-1:0] w_regs [NREG_P];
    logic [NREG_P-1:0]   w_wr_sel;
    logic [NREG_P-1:1]   r_wmask;
    logic                w_byp1;
    logic                w_byp2;

    always_comb begin
        w_wr_sel = '0;
        if (we && (wa != '0)) begin
            w_wr_sel[wa] = 1'b1;
        end
    end

    assign w_regs[0] = '0;

    for (genvar g = 1; g < NREG_P; g++) begin : g_reg
        reg_word #(.W(DATA_W_P)) u_reg (
            .clk (clk),
            .rst (rst),
            .we  (w_wr_sel[g]),
            .d   (wd),
            .q   (w_regs[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wmask <= '0;
        end else begin
            r_wmask <= r_wmask | w_wr_sel[NREG_P-1:1];
        end
    end

    assign wmask = {r_wmask, 1'b1};

    // Bypass is gated by !rst so outputs read zero throughout reset.
    assign w_byp1 = BYPASS && we && !rst && (wa == ra1) && (wa != '0);
    assign w_byp2 = BYPASS && we && !rst && (wa == ra2) && (wa != '0);

    always_comb begin
        rd1        = '0;
        rd2        = '0;
        rd1_uninit = 1'b0;
        rd2_uninit = 1'b0;
        if (!rst) begin
            if (w_byp1) begin
                rd1 = wd;
            end else begin
                rd1 = w_regs[ra1];
            end
            if (w_byp2) begin
                rd2 = wd;
            end else begin
                rd2 = w_regs[ra2];
            end
        end
        rd1_uninit = (ra1 != '0) && !(wmask[ra1] || w_byp1);
        rd2_uninit = (ra2 != '0) && !(wmask[ra2] || w_byp2);
    end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Bench for reg_file_8x16: directed scenarios plus random traffic against an array model,
// with a BYPASS=1 and a BYPASS=0 instance driven in parallel.
module tb_reg_file_8x16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [2:0]  wa  = '0;
    logic [15:0] wd  = '0;
    logic [2:0]  ra1 = '0;
    logic [2:0]  ra2 = '0;

    logic [15:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        un1_b1, un2_b1, un1_b0, un2_b0;
    logic [7:0]  wm_b1, wm_b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mdl [8];
    logic [7:0]  mdl_mask;

    always #5 clk = ~clk;

    reg_file_8x16 #(.BYPASS(1'b1)) u_dut_b1 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b1), .rd2(rd2_b1), .rd1_uninit(un1_b1), .rd2_uninit(un2_b1), .wmask(wm_b1)
    );

    reg_file_8x16 #(.BYPASS(1'b0)) u_dut_b0 (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b0), .rd2(rd2_b0), .rd1_uninit(un1_b0), .rd2_uninit(un2_b0), .wmask(wm_b0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        mdl_mask = 8'h01;
    endtask

    function automatic bit hit(input logic [2:0] ra, input bit byp);
        return byp && we && !rst && (wa == ra) && (ra != 3'd0);
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] ra, input bit byp);
        if (rst) return 16'h0000;
        if (hit(ra, byp)) return wd;
        return (ra == 3'd0) ? 16'h0000 : mdl[ra];
    endfunction

    function automatic logic exp_un(input logic [2:0] ra, input bit byp);
        return (ra != 3'd0) && !(mdl_mask[ra] || hit(ra, byp));
    endfunction

    task automatic check_all();
        chk("b1_rd1", rd1_b1, exp_rd(ra1, 1'b1));
        chk("b1_rd2", rd2_b1, exp_rd(ra2, 1'b1));
        chk("b1_un1", un1_b1, exp_un(ra1, 1'b1));
        chk("b1_un2", un2_b1, exp_un(ra2, 1'b1));
        chk("b1_wmask", wm_b1, mdl_mask);
        chk("b0_rd1", rd1_b0, exp_rd(ra1, 1'b0));
        chk("b0_rd2", rd2_b0, exp_rd(ra2, 1'b0));
        chk("b0_un1", un1_b0, exp_un(ra1, 1'b0));
        chk("b0_un2", un2_b0, exp_un(ra2, 1'b0));
        chk("b0_wmask", wm_b0, mdl_mask);
    endtask

    // One clock: drive at negedge, check combinational reads, then apply the write to the model.
    task automatic cycle(input bit r, input bit w, input logic [2:0] a, input logic [15:0] d,
                         input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clk);
        rst = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        if (r) mdl_reset();
        #1;
        check_all();
        @(posedge clk);
        if (!r && w && a != 3'd0) begin
            mdl[a]      = d;
            mdl_mask[a] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] mask_before;
        mdl_reset();
        #1;
        chk("reset_wmask", wm_b1, 8'h01);
        chk("reset_rd1", rd1_b1, 16'h0000);
        check_all();
        cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);

        // Async reset after loading R3
        cycle(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0);
        @(negedge clk);
        we = 1'b0; ra1 = 3'd3;
        #1;
        chk("r3_loaded", rd1_b1, 16'hBEEF);
        #2;
        rst = 1'b1;
        mdl_reset();
        #1;
        chk("async_rst_rd1", rd1_b1, 16'h0000);
        chk("async_rst_wmask", wm_b1, 8'h01);
        chk("async_rst_un1", un1_b1, 1'b1);
        check_all();

        // Reset spanning a write edge drops the write
        cycle(1'b1, 1'b1, 3'd7, 16'h7777, 3'd7, 3'd7);
        cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7);
        chk("rst_write_r7", rd1_b1, 16'h0000);
        chk("rst_write_mask7", wm_b1[7], 1'b0);

        // Write then read R5 on both ports
        cycle(1'b0, 1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
        cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
        chk("r5_rd1", rd1_b1, 16'h1234);
        chk("r5_rd2", rd2_b1, 16'h1234);
        chk("r5_wmask", wm_b1, 8'h21);

        // R0 write is a no-op
        mask_before = mdl_mask;
        cycle(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
        cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
        chk("r0_rd1", rd1_b1, 16'h0000);
        chk("r0_wmask", wm_b1, mask_before);

        // Bypass versus old value
        cycle(1'b0, 1'b1, 3'd2, 16'h0001, 3'd0, 3'd0);
        cycle(1'b0, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd2);
        cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd0);
        chk("r2_after", rd1_b0, 16'hA5A5);
        cycle(1'b0, 1'b1, 3'd2, 16'h0001, 3'd0, 3'd0);
        @(negedge clk);
        we = 1'b1; wa = 3'd2; wd = 16'hA5A5; ra1 = 3'd2; ra2 = 3'd4;
        #1;
        chk("byp1_rd1", rd1_b1, 16'hA5A5);
        chk("byp0_rd1", rd1_b0, 16'h0001);
        chk("byp0_un2", un2_b0, 1'b1);
        check_all();
        @(posedge clk);
        mdl[2] = 16'hA5A5; mdl_mask[2] = 1'b1;

        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Sweep: fill all registers, then read every pair
        for (int i = 1; i < 8; i++) begin
            cycle(1'b0, 1'b1, 3'(i), 16'(16'h1111 * i), 3'd0, 3'd0);
        end
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                cycle(1'b0, 1'b0, 3'd0, 16'h0, 3'(a), 3'(b));
            end
        end
        chk("sweep_wmask", wm_b1, 8'hFF);
        chk("sweep_r7", mdl[7], 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
